dpi_stream_dispatcher: RTL
==========================

Name: dpi_stream_dispatcher

Overview:
Upstream feeder for the per-category regex matcher wrappers. It accepts a byte stream of packets, each tagged with a flow key on its SOP beat, and maps each key to a 6-bit stream ID through a 64-entry fully-associative flow table. It then drives the matcher-side bus (`load_state`, `stream_id`, `new_stream_id`, `char_in`/`char_in_vld`, `eop`) with the timing the matchers require for state restore and save. One dispatcher fans out to all category matchers in parallel.

Parameters:
- KEY_W, 32, width of the flow key.
- NUM_STREAMS, 64, flow table entries; must equal 2**ID_W.
- ID_W, 6, stream ID width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: synchronous, active-low.
- s_vld, input, 1, upstream beat valid.
- s_rdy, output, 1, upstream beat accepted when s_vld && s_rdy.
- s_sop, input, 1, first beat of a packet.
- s_eop, input, 1, last beat of a packet.
- s_key, input, KEY_W, flow key; meaningful only on SOP beats.
- s_data, input, 8, payload byte (one per beat).
- flush, input, 1, request to invalidate the whole flow table.
- load_state, output, 1, one-cycle pulse: matchers restore or clear state.
- stream_id, output, ID_W, current stream; stable from load_state through eop.
- new_stream_id, output, 1, qualifies load_state: entry freshly allocated.
- char_in, output, 8, payload byte to matchers.
- char_in_vld, output, 1, char_in valid.
- eop, output, 1, one-cycle pulse: matchers commit count and save state.
- pkt_cnt, output, 16, packets dispatched; wraps.
- new_cnt, output, 16, allocations (misses); wraps.
- drop_cnt, output, 16, stray non-SOP beats discarded in IDLE; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0, all table valid bits 0, victim pointer 0, FSM in IDLE. Reset mid-packet abandons the packet with no eop emitted.
- All matcher-side outputs are registered.
- FSM states: IDLE, LOOKUP, LOAD, STREAM, EOPS.
- IDLE:
  - s_vld && s_sop: capture s_key without consuming the beat (s_rdy=0), go to LOOKUP.
  - s_vld && !s_sop: s_rdy=1, beat dropped, drop_cnt++.
  - A pending flush executes here (all valid bits cleared in one cycle) and takes priority over a waiting SOP for that cycle.
- LOOKUP (1 cycle): parallel compare of the captured key against all valid entries.
  - Hit: id = matching index, new = 0.
  - Miss: id = lowest-index invalid entry if any, else the victim pointer, which then increments mod NUM_STREAMS. Write key and set valid; new = 1.
  - Multiple hits cannot occur: keys are unique by construction.
- LOAD: drive load_state=1, stream_id=id, new_stream_id=new for exactly one cycle. pkt_cnt++, and new_cnt++ if new. Go to STREAM.
- STREAM:
  - s_rdy=1. Each accepted beat appears as char_in/char_in_vld=1 in the next cycle.
  - The first char_in_vld is no earlier than the cycle after load_state, matching the matcher's registered state_in_vld.
  - An accepted beat with s_eop goes to EOPS. A beat with s_sop inside STREAM is treated as payload.
- EOPS: s_rdy=0, char_in_vld=0, eop=1 for one cycle, exactly one cycle after the last char_in_vld. This lets the matcher's state_out reflect the last byte. Return to IDLE.
- Latency:
  - SOP visible at cycle T gives load_state at T+2, first SOP byte accepted at T+3, char_in_vld at T+4.
  - Minimum packet: a single beat with s_sop && s_eop gives one char followed by eop.
- flush asserted outside IDLE is latched and applied at the next IDLE cycle.
- The flow table is never modified while a packet is in flight.
- new_stream_id and stream_id hold their values after eop until the next LOAD.

Decomposition:
- Shared package: FSM state encoding, KEY_W/ID_W defaults, counter width constant.
- One sub-module, dpi_flow_table: key/valid arrays, parallel compare, first-free priority encoder, victim pointer, flush. It exposes lookup_req/key and returns hit/id/new one cycle later.
- The FSM and counters stay in the top module.

Test Plan:
- Key 0xA1B2C3D4, 3-byte packet after reset: load_state at T+2 with new_stream_id=1 and stream_id=0. Then chars at T+4..T+6, eop at T+7; pkt_cnt=1, new_cnt=1.
- Same key again: stream_id=0, new_stream_id=0; a different key gets stream_id=1, new_stream_id=1.
- 64 distinct keys then a 65th: the 65th gets id 0 (victim) and a 66th gets id 1; replaying the original key 0 misses with new_stream_id=1.
- Stray non-SOP beats 0x11, 0x22 in IDLE: s_rdy=1, no char_in_vld, drop_cnt=2.
- flush mid-packet: the current packet completes with eop. The next packet with a previously seen key gets new_stream_id=1, stream_id=0.
- s_vld toggled 1/0 during STREAM and rst_n pulsed mid-packet: char_in_vld gaps mirror input gaps with no eop on reset, and all counters read 0 after reset.

Source files
------------

// File: rtl/dpi_stream_dispatcher_pkg.sv
// Shared types and default sizes for the DPI stream dispatcher and its flow table.
package dpi_stream_dispatcher_pkg;
  localparam int KEY_W_DEF       = 32;
  localparam int NUM_STREAMS_DEF = 64;
  localparam int ID_W_DEF        = 6;
  localparam int CNT_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LOAD,
    ST_STREAM,
    ST_EOPS
  } state_e;
endpackage

// File: rtl/dpi_stream_dispatcher_if.sv
// Upstream byte stream plus the matcher-side restore/stream/save bus.
interface dpi_stream_dispatcher_if
  import dpi_stream_dispatcher_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int ID_W  = ID_W_DEF
);
  logic             s_vld;
  logic             s_rdy;
  logic             s_sop;
  logic             s_eop;
  logic [KEY_W-1:0] s_key;
  logic [7:0]       s_data;
  logic             load_state;
  logic [ID_W-1:0]  stream_id;
  logic             new_stream_id;
  logic [7:0]       char_in;
  logic             char_in_vld;
  logic             eop;

  modport slave (
    input  s_vld, s_sop, s_eop, s_key, s_data,
    output s_rdy, load_state, stream_id, new_stream_id, char_in, char_in_vld, eop
  );

  modport master (
    output s_vld, s_sop, s_eop, s_key, s_data,
    input  s_rdy, load_state, stream_id, new_stream_id, char_in, char_in_vld, eop
  );
endinterface

// File: rtl/dpi_flow_table.sv
// Fully-associative key -> stream ID table; hit/id are registered one cycle after lookup_req.
// A miss allocates the lowest free entry, otherwise the round-robin victim.
module dpi_flow_table
  import dpi_stream_dispatcher_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int ID_W        = ID_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_req,
  input  logic [KEY_W-1:0] lookup_key,
  input  logic             flush,
  output logic             hit,
  output logic [ID_W-1:0]  id
);
  logic [KEY_W-1:0]       keys_q [NUM_STREAMS];
  logic [KEY_W-1:0]       keys_d [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid_q, valid_d;
  logic [ID_W-1:0]        victim_q, victim_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   hit_q, hit_d;
  logic [ID_W-1:0]        hit_idx, free_idx;
  logic                   any_hit, any_free;

  // Scanning downwards leaves the lowest matching/free index as the winner.
  always_comb begin
    any_hit  = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid_q[i] && keys_q[i] == lookup_key) begin
        any_hit = 1'b1;
        hit_idx = ID_W'(i);
      end
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    keys_d   = keys_q;
    valid_d  = valid_q;
    victim_d = victim_q;
    id_d     = id_q;
    hit_d    = hit_q;
    if (flush) begin
      valid_d = '0;
    end else if (lookup_req) begin
      hit_d = any_hit;
      if (any_hit) begin
        id_d = hit_idx;
      end else begin
        id_d = any_free ? free_idx : victim_q;
        if (!any_free) victim_d = victim_q + 1'b1;
        keys_d[id_d]  = lookup_key;
        valid_d[id_d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      victim_q <= '0;
      id_q     <= '0;
      hit_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      victim_q <= victim_d;
      id_q     <= id_d;
      hit_q    <= hit_d;
    end
  end

  // Key storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    keys_q <= keys_d;
  end

  assign hit = hit_q;
  assign id  = id_q;
endmodule

// File: rtl/dpi_stream_dispatcher.sv
// Maps SOP flow keys to stream IDs and drives the matcher bus: load_state at SOP+2, chars one cycle
// after acceptance, eop one cycle after the last char. s_rdy is low while a lookup/load or eop is pending.
module dpi_stream_dispatcher
  import dpi_stream_dispatcher_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int ID_W        = ID_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  dpi_stream_dispatcher_if.slave bus,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       new_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);
  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic             load_q, load_d;
  logic             new_q, new_d;
  logic             cvld_q, cvld_d;
  logic             eop_q, eop_d;
  logic [ID_W-1:0]  sid_q, sid_d;
  logic [7:0]       char_q, char_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, newc_q, newc_d, drop_q, drop_d;
  logic             rdy_c, lookup_req, tbl_flush, tbl_hit;
  logic [ID_W-1:0]  tbl_id;

  dpi_flow_table #(
    .KEY_W       (KEY_W),
    .NUM_STREAMS (NUM_STREAMS),
    .ID_W        (ID_W)
  ) u_flow_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_req (lookup_req),
    .lookup_key (bus.s_key),
    .flush      (tbl_flush),
    .hit        (tbl_hit),
    .id         (tbl_id)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush;
    load_d       = 1'b0;
    eop_d        = 1'b0;
    cvld_d       = 1'b0;
    char_d       = char_q;
    sid_d        = sid_q;
    new_d        = new_q;
    pkt_d        = pkt_q;
    newc_d       = newc_q;
    drop_d       = drop_q;
    rdy_c        = 1'b0;
    lookup_req   = 1'b0;
    tbl_flush    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_c = bus.s_vld && !bus.s_sop;
        if (bus.s_vld && !bus.s_sop && drop_q != '1) drop_d = drop_q + 1'b1;
        // A flush owns the table this cycle; a waiting SOP is held off until it is done.
        if (flush_pend_q || flush) begin
          tbl_flush    = 1'b1;
          flush_pend_d = 1'b0;
        end else if (bus.s_vld && bus.s_sop) begin
          lookup_req = 1'b1;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        load_d  = 1'b1;
        sid_d   = tbl_id;
        new_d   = !tbl_hit;
        pkt_d   = pkt_q + 1'b1;
        if (!tbl_hit) newc_d = newc_q + 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_STREAM;
      ST_STREAM: begin
        rdy_c = 1'b1;
        if (bus.s_vld) begin
          char_d = bus.s_data;
          cvld_d = 1'b1;
          if (bus.s_eop) state_d = ST_EOPS;
        end
      end
      ST_EOPS: begin
        eop_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      load_q       <= 1'b0;
      new_q        <= 1'b0;
      cvld_q       <= 1'b0;
      eop_q        <= 1'b0;
      sid_q        <= '0;
      char_q       <= '0;
      pkt_q        <= '0;
      newc_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      load_q       <= load_d;
      new_q        <= new_d;
      cvld_q       <= cvld_d;
      eop_q        <= eop_d;
      sid_q        <= sid_d;
      char_q       <= char_d;
      pkt_q        <= pkt_d;
      newc_q       <= newc_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.s_rdy         = rdy_c;
  assign bus.load_state    = load_q;
  assign bus.stream_id     = sid_q;
  assign bus.new_stream_id = new_q;
  assign bus.char_in       = char_q;
  assign bus.char_in_vld   = cvld_q;
  assign bus.eop           = eop_q;
  assign pkt_cnt           = pkt_q;
  assign new_cnt           = newc_q;
  assign drop_cnt          = drop_q;
endmodule
